cfg_frame_loader: RTL and testbench
===================================

Name: cfg_frame_loader

Overview:
- Fabric configuration writer: receives a byte-wide configuration stream and assembles it into a logic_block config word and a bidir_switch_block config word.
- Drives those words onto the blocks' configuration inputs.
- Shadow registers with checksum gating: a corrupted frame never reaches live configuration.
- Sits between the external programming interface and the fabric tiles.

Parameters:
- LB_CFG_W, 5, logic_block config width ({sync, mem[3:0]})
- BSB_CFG_W, 108, bidir_switch_block config width
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clk  input  1  fabric clock, rising edge
- rst  input  1  asynchronous reset, active-high
- data_in  input  8  stream byte
- data_valid  input  1  data_in valid this cycle
- data_ready  output  1  loader accepts byte this cycle
- cfg_lb  output  LB_CFG_W  live logic_block config, bit 4 = sync, bits 3:0 = mem
- cfg_bsb  output  BSB_CFG_W  live switch block config
- busy  output  1  frame in progress (past SYNC)
- done  output  1  one-cycle pulse, frame committed
- err  output  1  one-cycle pulse, frame rejected

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values:
  - cfg_lb = 0, cfg_bsb = 0
  - busy = 0, done = 0, err = 0
  - data_ready = 0 while rst is high; state = IDLE.
- Byte transfer occurs on a rising edge with data_valid && data_ready. A cycle with data_valid = 0 is a stall: no state change, no timeout.
- Frame format: SYNC_BYTE, TARGET, PAYLOAD[0..N-1], CHK.
  - TARGET 8'h00: logic_block, N = ceil(LB_CFG_W/8) = 1.
  - TARGET 8'h01: switch block, N = ceil(BSB_CFG_W/8) = 14.
- Payload packing is LSB-first: payload byte k bit j maps to shadow bit 8k+j. Bits at or beyond the target width are ignored.
- CHK must equal the XOR of TARGET and all payload bytes. SYNC_BYTE is excluded.
- States:
  - IDLE: ready = 1. An accepted byte equal to SYNC_BYTE moves to TARGET; any other byte is discarded.
  - TARGET: ready = 1. On accept, 00 or 01 latches the target, clears the shadow register and byte counter, seeds the checksum with TARGET, then moves to PAYLOAD. Any other value moves to RESP with err.
  - PAYLOAD: ready = 1. Each accept writes the shadow byte, XORs it into the checksum and increments the counter. After byte N-1, move to CHECK.
  - CHECK: ready = 1. On accept, a match copies shadow into the selected live register (cfg_lb or cfg_bsb only; the other is untouched) and moves to RESP with done. A mismatch moves to RESP with err and leaves live registers unchanged.
  - RESP: exactly one cycle with ready = 0, and done or err high. Then IDLE.
- Latency: the live cfg update, done and err are all visible the cycle after the CHK byte is accepted.
- busy = 1 in TARGET, PAYLOAD, CHECK and RESP; 0 in IDLE.
- A SYNC_BYTE value inside TARGET, PAYLOAD or CHECK is treated as data. There is no resynchronisation mid-frame.
- Reset mid-frame immediately returns to IDLE and zeroes the live cfg and shadow registers.
- Live cfg outputs are stable except on the commit edge, so downstream tiles never see partial words.
- Back-to-back frames:
  - The first SYNC after RESP is accepted in the cycle following RESP.
  - Consecutive frames to the same target overwrite the whole word.

Test Plan:
- LB load: A5 00 06 06 -> one cycle after CHK, cfg_lb = 5'b00110 and done pulses once; cfg_bsb stays 0; err never asserts.
- Bad checksum: after the load above, send A5 00 1F 00 -> err pulses; cfg_lb stays 5'b00110.
- BSB load: A5 01, then payload 10 00 04 00 48 00 10 00 00 00 00 00 00 F0, then CHK BD.
  - Expect cfg_bsb bits 4, 18, 35, 38, 52 = 1 and all others 0; done pulses.
  - The F0 nibble (bits 108–111) is ignored, but F0 still counts in CHK.
- Garbage, stalls and bad target: 00 FF 3C, then A5 02 -> first three bytes ignored, err pulses after 02, state returns to IDLE.
  - Repeat the LB load with data_valid toggled every other cycle -> same result as the LB load.
- Reset and back-to-back:
  - Assert rst after the 7th BSB payload byte -> cfg_lb = 0, cfg_bsb = 0, busy = 0, done = 0 immediately.
  - Then two LB frames back-to-back (A5 00 06 06, A5 00 19 19) -> data_ready low only in each RESP cycle; final cfg_lb = 5'b11001.

Source files
------------

// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: assembles a byte-wide configuration stream into shadow
// registers and commits them to the live logic_block / switch-block config
// words only when the frame checksum matches.
//
// Handshake: a byte moves on a rising edge where data_valid && data_ready.
// data_valid low is a stall and changes nothing. data_ready is high in every
// state except the single RESP cycle, and it is held low during reset.
module cfg_frame_loader #(
  parameter int          LB_CFG_W  = 5,
  parameter int          BSB_CFG_W = 108,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic [LB_CFG_W-1:0]  cfg_lb,
  output logic [BSB_CFG_W-1:0] cfg_bsb,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int LB_BYTES  = (LB_CFG_W + 7) / 8;
  localparam int BSB_BYTES = (BSB_CFG_W + 7) / 8;
  localparam int MAX_BYTES = (LB_BYTES > BSB_BYTES) ? LB_BYTES : BSB_BYTES;
  localparam int SHADOW_W  = (LB_CFG_W > BSB_CFG_W) ? LB_CFG_W : BSB_CFG_W;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);

  localparam logic [CNT_W-1:0] LB_LAST  = CNT_W'(LB_BYTES - 1);
  localparam logic [CNT_W-1:0] BSB_LAST = CNT_W'(BSB_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TARGET  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 tgt_bsb;   // 0 = logic_block, 1 = switch block
  logic [CNT_W-1:0]     cnt;
  logic [7:0]           chk;
  logic [SHADOW_W-1:0]  shadow;
  logic                 resp_ok;
  logic                 accept;
  logic                 last_byte;
  logic                 tgt_valid;

  assign accept    = data_valid && data_ready;
  assign last_byte = (cnt == (tgt_bsb ? BSB_LAST : LB_LAST));
  assign tgt_valid = (data_in == 8'h00) || (data_in == 8'h01);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode; SYNC_BYTE only matters in IDLE, elsewhere it is data.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (accept && data_in == SYNC_BYTE) state_next = S_TARGET;
      S_TARGET:  if (accept) state_next = tgt_valid ? S_PAYLOAD : S_RESP;
      S_PAYLOAD: if (accept && last_byte) state_next = S_CHECK;
      S_CHECK:   if (accept) state_next = S_RESP;
      S_RESP:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; done/err are exactly the RESP cycle.
  always_comb begin
    data_ready = !rst && (state != S_RESP);
    busy       = (state != S_IDLE);
    done       = (state == S_RESP) && resp_ok;
    err        = (state == S_RESP) && !resp_ok;
  end

  // Frame datapath: shadow assembly, running checksum and gated commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_bsb <= 1'b0;
      cnt     <= '0;
      chk     <= 8'h00;
      shadow  <= '0;
      resp_ok <= 1'b0;
      cfg_lb  <= '0;
      cfg_bsb <= '0;
    end else if (accept) begin
      case (state)
        S_TARGET: begin
          if (tgt_valid) begin
            tgt_bsb <= data_in[0];
            shadow  <= '0;
            cnt     <= '0;
            chk     <= data_in;
          end else begin
            resp_ok <= 1'b0;
          end
        end
        S_PAYLOAD: begin
          // LSB-first packing; bits past the shadow width are dropped.
          for (int i = 0; i < SHADOW_W; i++) begin
            if ((i / 8) == int'(cnt)) shadow[i] <= data_in[i % 8];
          end
          chk <= chk ^ data_in;
          cnt <= cnt + 1'b1;
        end
        S_CHECK: begin
          if (data_in == chk) begin
            resp_ok <= 1'b1;
            if (tgt_bsb) cfg_bsb <= shadow[BSB_CFG_W-1:0];
            else         cfg_lb  <= shadow[LB_CFG_W-1:0];
          end else begin
            resp_ok <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb_cfg_frame_loader: directed frames for cfg_frame_loader. The driver pushes
// the expected response (done/err plus live cfg words) before sending each
// CHK/TARGET byte that ends a frame; a monitor pops on every done/err pulse.
module tb_cfg_frame_loader;

  localparam int LB_W  = 5;
  localparam int BSB_W = 108;
  localparam int EXP_W = 1 + LB_W + BSB_W;

  logic             clk;
  logic             rst;
  logic [7:0]       data_in;
  logic             data_valid;
  logic             data_ready;
  logic [LB_W-1:0]  cfg_lb;
  logic [BSB_W-1:0] cfg_bsb;
  logic             busy;
  logic             done;
  logic             err;

  logic [EXP_W-1:0] exp_q[$];
  int               n_cmp = 0;
  int               n_bad = 0;

  logic [BSB_W-1:0] bsb_exp;
  logic [LB_W-1:0]  prev_lb;
  logic [BSB_W-1:0] prev_bsb;

  cfg_frame_loader dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .cfg_lb     (cfg_lb),
    .cfg_bsb    (cfg_bsb),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one byte, waiting for data_ready; optional idle cycle afterwards.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int budget;
    budget = 0;
    data_in    = b;
    data_valid = 1'b1;
    while (!data_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!data_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: byte %h not accepted, data_ready %b", b, data_ready);
      data_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    if (gap) begin
      data_in = 8'hA5;  // stalled garbage must be ignored
      @(posedge clk); #1;
    end
  endtask

  task automatic push_exp(input bit is_done, input logic [LB_W-1:0] lb, input logic [BSB_W-1:0] bsb);
    exp_q.push_back({is_done, lb, bsb});
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: scoreboard pops, RESP-only ready drop, and cfg stability.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst) begin
      prev_lb  = cfg_lb;
      prev_bsb = cfg_bsb;
    end else begin
      check("ready_vs_resp", {127'd0, data_ready}, {127'd0, !(done || err)});
      if (done || err) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp: done %b err %b with empty queue at %0t", done, err, $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_kind", {126'd0, done, err}, {126'd0, e[EXP_W-1], !e[EXP_W-1]});
          check("resp_cfg_lb", {123'd0, cfg_lb}, {123'd0, e[BSB_W +: LB_W]});
          check("resp_cfg_bsb", {20'd0, cfg_bsb}, {20'd0, e[BSB_W-1:0]});
        end
      end else if (cfg_lb !== prev_lb || cfg_bsb !== prev_bsb) begin
        n_cmp++;
        n_bad++;
        $display("FAIL cfg_glitch: cfg changed without done, lb %h bsb %h at %0t", cfg_lb, cfg_bsb, $time);
      end
      prev_lb  = cfg_lb;
      prev_bsb = cfg_bsb;
    end
  end

  // Directed stimulus.
  initial begin
    logic [7:0] bsb_pay [14];
    bsb_pay = '{8'h10, 8'h00, 8'h04, 8'h00, 8'h48, 8'h00, 8'h10,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
    bsb_exp = '0;
    bsb_exp[4]  = 1'b1;
    bsb_exp[18] = 1'b1;
    bsb_exp[35] = 1'b1;
    bsb_exp[38] = 1'b1;
    bsb_exp[52] = 1'b1;

    rst        = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    #2;
    check("rst_cfg_lb", {123'd0, cfg_lb}, 128'd0);
    check("rst_cfg_bsb", {20'd0, cfg_bsb}, 128'd0);
    check("rst_flags", {124'd0, data_ready, busy, done, err}, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("idle_ready", {126'd0, data_ready, busy}, {126'd0, 2'b10});

    // LB load.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    check("busy_in_frame", {127'd0, busy}, 128'd1);
    send_byte(8'h06, 1'b0);
    push_exp(1'b1, 5'b00110, '0);
    send_byte(8'h06, 1'b0);

    // Bad checksum leaves cfg_lb alone.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h1F, 1'b0);
    push_exp(1'b0, 5'b00110, '0);
    send_byte(8'h00, 1'b0);

    // BSB load; A5 inside payload would be data, F0 upper nibble dropped.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int k = 0; k < 14; k++) send_byte(bsb_pay[k], 1'b0);
    push_exp(1'b1, 5'b00110, bsb_exp);
    send_byte(8'hBD, 1'b0);

    // Garbage then bad target.
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hA5, 1'b0);
    push_exp(1'b0, 5'b00110, bsb_exp);
    send_byte(8'h02, 1'b0);
    idle_cycles(2);
    check("idle_after_err", {126'd0, data_ready, busy}, {126'd0, 2'b10});

    // LB load with data_valid toggling every other cycle.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h06, 1'b1);
    push_exp(1'b1, 5'b00110, bsb_exp);
    send_byte(8'h06, 1'b1);
    idle_cycles(2);

    // Reset after the 7th BSB payload byte.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int k = 0; k < 7; k++) send_byte(bsb_pay[k], 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_cfg_lb", {123'd0, cfg_lb}, 128'd0);
    check("midrst_cfg_bsb", {20'd0, cfg_bsb}, 128'd0);
    check("midrst_flags", {124'd0, data_ready, busy, done, err}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("post_rst_idle", {126'd0, data_ready, busy}, {126'd0, 2'b10});

    // Back-to-back LB frames.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h06, 1'b0);
    push_exp(1'b1, 5'b00110, '0);
    send_byte(8'h06, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h19, 1'b0);
    push_exp(1'b1, 5'b11001, '0);
    send_byte(8'h19, 1'b0);
    idle_cycles(3);
    check("final_cfg_lb", {123'd0, cfg_lb}, {123'd0, 5'b11001});
    check("final_cfg_bsb", {20'd0, cfg_bsb}, 128'd0);
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
